std_skid_buf: RTL and testbench

Two-entry elastic valid/ready buffer with registered backpressure. It breaks the combinational ready path between an L1D pipeline producer and its consumer while sustaining one transfer per cycle. Storage is two `std_dffrve` data registers: main and skid. The block sits directly upstream of pipeline-stage registers and feeds them `d`/`en`-qualified data through its output handshake.

---
 rtl/std_cells_pkg.sv | 11 +
 rtl/std_dffrve.sv | 30 +++
 rtl/std_skid_buf.sv | 128 ++++++++++++
 tb/tb_std_skid_buf.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/std_cells_pkg.sv
// Shared types for the std_* cell library.
package std_cells_pkg;

  // Encoding is chosen so the state value doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage : std_cells_pkg

// File: rtl/std_dffrve.sv
// Register with async active-low reset to a parameterised value and a load enable.
module std_dffrve #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Load new data only when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // Storage flop with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_q <= RST_VAL;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule : std_dffrve

// File: rtl/std_skid_buf.sv
// Two-entry elastic valid/ready buffer; in_rdy and out_vld come straight from flops.
//
//   state | meaning
//   ------+------------------------------------------
//   EMPTY | no entry held, out_vld=0, in_rdy=1
//   ONE   | main valid,    out_vld=1, in_rdy=1
//   FULL  | main and skid valid, out_vld=1, in_rdy=0
module std_skid_buf
  import std_cells_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       cnt
);

  skid_state_e      state_d;
  skid_state_e      state_q;
  logic [1:0]       state_raw;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_rdy_d;
  logic             in_rdy_q;
  logic             out_vld_d;
  logic             out_vld_q;
  logic             push;
  logic             pop;

  assign state_q = skid_state_e'(state_raw);
  assign push    = in_vld & in_rdy_q;
  assign pop     = out_vld_q & out_rdy;

  // Next state, register load enables and the registered handshake outputs.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_en = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_en = 1'b1;
        end else if (push) begin
          state_d = FULL;
          skid_en = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything stored; a concurrent pop has already been taken
    // by the consumer, and the data registers simply keep their contents.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
    in_rdy_d  = (state_d != FULL);
    out_vld_d = (state_d != EMPTY);
  end

  // Dedicated flops so neither handshake output decodes state combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  std_dffrve #(.WIDTH(2), .RST_VAL(EMPTY)) u_state (
    .clk  (clk),
    .rstn (rstn),
    .en   (1'b1),
    .d    (state_d),
    .q    (state_raw)
  );

  std_dffrve #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
    .clk  (clk),
    .rstn (rstn),
    .en   (main_en),
    .d    (main_d),
    .q    (main_q)
  );

  std_dffrve #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
    .clk  (clk),
    .rstn (rstn),
    .en   (skid_en),
    .d    (in_data),
    .q    (skid_q)
  );

  assign in_rdy   = in_rdy_q;
  assign out_vld  = out_vld_q;
  assign out_data = main_q;
  assign cnt      = state_raw;

endmodule : std_skid_buf

// File: tb/tb_std_skid_buf.sv
// Directed self-checking bench for std_skid_buf.
module tb_std_skid_buf;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic       in_vld;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       out_vld;
  logic       out_rdy;
  logic [7:0] out_data;
  logic [1:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  std_skid_buf #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .cnt      (cnt)
  );

  // Advance past one rising edge; outputs are settled when this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_vld = 1'b0; in_data = 8'h00; out_rdy = 1'b0;
    step(); step();
    #3 rstn = 1'b1;
    step();
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b exp 1", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    in_vld = 1'b1; in_data = 8'h11;
    step();
    in_vld = 1'b0;
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL first_push_vld got %b exp 1", out_vld); end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL first_push_data got %h exp 11", out_data); end
    checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL first_push_cnt got %0d exp 1", cnt); end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL first_drain_cnt got %0d exp 0", cnt); end
  endtask

  task automatic test_streaming();
    logic [7:0] exp_pop;
    int         pops;
    exp_pop = 8'h01;
    pops    = 0;
    out_rdy = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      in_vld  = (i <= 16);
      in_data = 8'(i);
      if (out_vld && out_rdy) begin
        checks++; if (out_data !== exp_pop) begin errors++; $display("FAIL stream_pop_data got %h exp %h", out_data, exp_pop); end
        exp_pop++;
        pops++;
      end
      step();
      if (i <= 16) begin
        checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL stream_cnt cycle %0d got %0d exp 1", i, cnt); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL stream_in_rdy cycle %0d got %b exp 1", i, in_rdy); end
      end
    end
    in_vld = 1'b0;
    checks++; if (pops != 16) begin errors++; $display("FAIL stream_pop_count got %0d exp 16", pops); end
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL stream_end_cnt got %0d exp 0", cnt); end
    out_rdy = 1'b0;
  endtask

  task automatic test_stall();
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'hA0;
    step();
    in_data = 8'hA1;
    step();
    in_vld = 1'b0;
    checks++; if (cnt !== 2'd2) begin errors++; $display("FAIL stall_cnt got %0d exp 2", cnt); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall_in_rdy got %b exp 0", in_rdy); end
    checks++; if (out_data !== 8'hA0) begin errors++; $display("FAIL stall_head got %h exp a0", out_data); end
    step();
    checks++; if (cnt !== 2'd2) begin errors++; $display("FAIL stall_hold_cnt got %0d exp 2", cnt); end
    out_rdy = 1'b1;
    checks++; if (out_vld !== 1'b1 || out_data !== 8'hA0) begin errors++; $display("FAIL stall_pop0 got vld %b data %h exp 1 a0", out_vld, out_data); end
    step();
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL stall_rdy_rise got %b exp 1", in_rdy); end
    checks++; if (out_vld !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL stall_pop1 got vld %b data %h exp 1 a1", out_vld, out_data); end
    checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL stall_mid_cnt got %0d exp 1", cnt); end
    step();
    checks++; if (cnt !== 2'd0 || out_vld !== 1'b0) begin errors++; $display("FAIL stall_drained got cnt %0d vld %b exp 0 0", cnt, out_vld); end
    out_rdy = 1'b0;
  endtask

  task automatic test_push_pop();
    in_vld = 1'b1; in_data = 8'h33;
    step();
    checks++; if (out_data !== 8'h33 || cnt !== 2'd1) begin errors++; $display("FAIL pp_setup got data %h cnt %0d exp 33 1", out_data, cnt); end
    in_data = 8'h44; out_rdy = 1'b1;
    step();
    in_vld = 1'b0;
    checks++; if (out_data !== 8'h44) begin errors++; $display("FAIL pp_data got %h exp 44", out_data); end
    checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL pp_cnt got %0d exp 1", cnt); end
    step();
    out_rdy = 1'b0;
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL pp_drain got %0d exp 0", cnt); end
  endtask

  task automatic test_flush();
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'h55;
    step();
    in_data = 8'h66;
    step();
    checks++; if (cnt !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d exp 2", cnt); end
    flush = 1'b1; out_rdy = 1'b1; in_vld = 1'b1; in_data = 8'h77;
    checks++; if (out_vld !== 1'b1 || out_data !== 8'h55) begin errors++; $display("FAIL flush_pop got vld %b data %h exp 1 55", out_vld, out_data); end
    step();
    flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", cnt); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL flush_vld got %b exp 0", out_vld); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy got %b exp 1", in_rdy); end
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL flush_data_held got %h exp 55", out_data); end
    step();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got %b exp 0", out_vld); end
    // Flush in ONE with an accepted-looking push: the push must be dropped.
    in_vld = 1'b1; in_data = 8'h88;
    step();
    flush = 1'b1; in_data = 8'h99;
    step();
    flush = 1'b0; in_vld = 1'b0;
    checks++; if (cnt !== 2'd0 || out_vld !== 1'b0) begin errors++; $display("FAIL flush_one got cnt %0d vld %b exp 0 0", cnt, out_vld); end
    checks++; if (out_data !== 8'h88) begin errors++; $display("FAIL flush_push_dropped got %h exp 88", out_data); end
  endtask

  task automatic test_async_reset();
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'hB0;
    step();
    in_data = 8'hB1;
    step();
    in_vld = 1'b0;
    checks++; if (cnt !== 2'd2) begin errors++; $display("FAIL arst_fill got %0d exp 2", cnt); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL arst_vld got %b exp 0", out_vld); end
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", cnt); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL arst_rdy got %b exp 1", in_rdy); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL arst_data got %h exp 00", out_data); end
    step();
    #2 rstn = 1'b1;
    step();
    in_vld = 1'b1; in_data = 8'hC0;
    step();
    in_vld = 1'b0;
    checks++; if (out_vld !== 1'b1 || out_data !== 8'hC0 || cnt !== 2'd1) begin errors++; $display("FAIL arst_first_push got vld %b data %h cnt %0d exp 1 c0 1", out_vld, out_data, cnt); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_push_pop();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_std_skid_buf
